pipeline_stage_regs: RTL and testbench
======================================

// Module: pipeline_stage_regs
// PURPOSE
// - Three inter-stage registers of the 5-stage MIPS pipeline in one block: IF/ID, ID/EX, EX/MEM.
// - Each captures its stage's data and control on the rising clk edge and presents it to the next stage.
// - Sits between PC/instr ROM, decode/reg file, ALU and data memory. MEM/WB is out of scope.
// PARAMETERS
// - DATA_W   32  datapath width (PC, instruction, operands, ALU results)
// - RADDR_W   5  register-file address width
// - ALUOP_W   2  ALUOp control width
// PORTS (name direction width meaning)
// - clk    in   1  single clock, rising edge
// - reset  in   1  asynchronous, active-low; 0 clears every output
// - ifid_enable  in  1  1 = load IF/ID, 0 = hold (driven by ~stall)
// - ifid_pc_plus1_i / _o  in/out  DATA_W  incremented PC
// - ifid_instr_i / _o  in/out  DATA_W  fetched instruction
// - idex_stall  in  1  load-use stall from hazard unit; inserts bubble
// - idex_pc_plus1_i / _o  in/out  DATA_W  PC+1 forwarded from IF/ID
// - idex_rs_i, idex_rt_i / _o  in/out  DATA_W  register-file read data
// - idex_sext_i / _o  in/out  DATA_W  sign-extended immediate
// - idex_rs_addr_i, idex_rt_addr_i, idex_rd_addr_i / _o  in/out  RADDR_W  instr[25:21],[20:16],[15:11]
// - idex_instr_i / _o  in/out  DATA_W  instruction (funct field used in EX)
// - idex_{regdest,jump,branch,memread,memtoreg,memwrite,alusrc,regwrite}_i / _o  in/out  1 each  decode control
// - idex_aluop_i / _o  in/out  ALUOP_W  ALU operation class
// - exmem_branch_addr_i / _o  in/out  DATA_W  computed branch target
// - exmem_alu_res_i / _o  in/out  DATA_W  ALU result / memory address
// - exmem_rt_i / _o  in/out  DATA_W  store data
// - exmem_zero_i / _o  in/out  1  ALU zero flag
// - exmem_dest_addr_i / _o  in/out  RADDR_W  selected destination register
// - exmem_{jump,branch,memread,memtoreg,memwrite,regwrite}_i / _o  in/out  1 each  EX control passed on
// BEHAVIOUR
// - Every output is a flop; no combinational input-to-output path. Latency is 1 cycle per stage.
// - reset=0: all outputs go to 0 immediately, with no clock edge needed.
//   - A cleared IF/ID instruction is 0x00000000 and acts as a NOP.
//   - Reset dominates enable and stall. Reset asserted mid-operation discards all in-flight state.
// - IF/ID: on posedge with ifid_enable=1, load both fields. With ifid_enable=0, hold the previous value.
// - ID/EX: loads every cycle.
//   - idex_stall=1: all 9 control outputs (including aluop) load 0 to form a bubble; data, address and instr fields still load.
//   - The bubble therefore never writes a register or memory and never branches or jumps.
// - EX/MEM: loads every field unconditionally every cycle. There is no stall or flush input.
// - Stall cycle, combined: IF/ID holds, and ID/EX emits a bubble the same edge. On release, the held instruction enters ID/EX once.
// - Width rules: fields pass through bit-exact. No extension, truncation or arithmetic is done inside this block.
// STRUCTURE
// - Shared package pipeline_pkg holds:
//   - the DATA_W, RADDR_W and ALUOP_W constants;
//   - typedefs id_ex_ctrl_t (9 fields) and ex_mem_ctrl_t (6 fields).
// - One natural sub-module, pipe_reg #(W): async active-low clear, load enable, synchronous zero.
//   - It is instantiated per stage; the top level is wiring plus bubble muxing.
// TESTING
// - Reset: hold reset=0 with random inputs and toggling clk -> every output is 0; outputs also clear mid-cycle, without a clock edge.
// - IF/ID hold: load instr=0x8C220004, pc+1=5, then enable=0 and inputs=0xFFFFFFFF for 3 edges -> outputs stay 0x8C220004 and 5.
// - ID/EX bubble: regwrite=1, memread=1, aluop=2'b10, rt_addr=3, stall=1 -> next edge all controls 0, rt_addr_o=3.
// - ID/EX normal: stall=0, rs=0x11, rt=0x22, sext=0xFFFFFFFC -> values appear after exactly 1 edge, unchanged.
// - EX/MEM: alu_res=0x10, zero=1, branch=1, dest=7 -> outputs 0x10, 1, 1, 7 after 1 edge. An async reset asserted between edges -> all 0.
// - Back-to-back: a 3-instruction stream with a 1-cycle stall on instr 2 -> instr 2 reaches EX/MEM one cycle late, with one bubble ahead of it.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared constants and control bundles for the IF/ID, ID/EX and EX/MEM
// inter-stage registers of the 5-stage MIPS pipeline.
package pipeline_pkg;

  localparam int DATA_W  = 32;
  localparam int RADDR_W = 5;
  localparam int ALUOP_W = 2;

  // Decode control carried from ID into EX. A bubble is all-zero.
  typedef struct packed {
    logic               regdest;
    logic               jump;
    logic               branch;
    logic               memread;
    logic               memtoreg;
    logic               memwrite;
    logic               alusrc;
    logic               regwrite;
    logic [ALUOP_W-1:0] aluop;
  } id_ex_ctrl_t;

  // Control still needed after EX, passed into MEM.
  typedef struct packed {
    logic jump;
    logic branch;
    logic memread;
    logic memtoreg;
    logic memwrite;
    logic regwrite;
  } ex_mem_ctrl_t;

  localparam int IDEX_CTRL_W  = $bits(id_ex_ctrl_t);
  localparam int EXMEM_CTRL_W = $bits(ex_mem_ctrl_t);

endpackage

// File: rtl/pipeline_stage_regs_pipe_reg.sv
// Generic pipeline register: async active-low clear, load enable and a
// synchronous zero that takes priority over the load (used for bubbles).
module pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_d;
  logic [W-1:0] q_q;

  // Next state: zero beats load, load beats hold.
  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (en_i) begin
      q_d = d_i;
    end else begin
      q_d = q_q;
    end
  end

  // State register, cleared immediately when reset is asserted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipeline_stage_regs.sv
// IF/ID, ID/EX and EX/MEM inter-stage registers. Every output is a flop;
// the only logic here is field packing and the ID/EX bubble on stall.
module pipeline_stage_regs #(
  parameter int DATA_W  = pipeline_pkg::DATA_W,
  parameter int RADDR_W = pipeline_pkg::RADDR_W,
  parameter int ALUOP_W = pipeline_pkg::ALUOP_W
) (
  input  logic               clk,
  input  logic               reset,
  // IF/ID
  input  logic               ifid_enable,
  input  logic [DATA_W-1:0]  ifid_pc_plus1_i,
  input  logic [DATA_W-1:0]  ifid_instr_i,
  output logic [DATA_W-1:0]  ifid_pc_plus1_o,
  output logic [DATA_W-1:0]  ifid_instr_o,
  // ID/EX
  input  logic               idex_stall,
  input  logic [DATA_W-1:0]  idex_pc_plus1_i,
  input  logic [DATA_W-1:0]  idex_rs_i,
  input  logic [DATA_W-1:0]  idex_rt_i,
  input  logic [DATA_W-1:0]  idex_sext_i,
  input  logic [RADDR_W-1:0] idex_rs_addr_i,
  input  logic [RADDR_W-1:0] idex_rt_addr_i,
  input  logic [RADDR_W-1:0] idex_rd_addr_i,
  input  logic [DATA_W-1:0]  idex_instr_i,
  input  logic               idex_regdest_i,
  input  logic               idex_jump_i,
  input  logic               idex_branch_i,
  input  logic               idex_memread_i,
  input  logic               idex_memtoreg_i,
  input  logic               idex_memwrite_i,
  input  logic               idex_alusrc_i,
  input  logic               idex_regwrite_i,
  input  logic [ALUOP_W-1:0] idex_aluop_i,
  output logic [DATA_W-1:0]  idex_pc_plus1_o,
  output logic [DATA_W-1:0]  idex_rs_o,
  output logic [DATA_W-1:0]  idex_rt_o,
  output logic [DATA_W-1:0]  idex_sext_o,
  output logic [RADDR_W-1:0] idex_rs_addr_o,
  output logic [RADDR_W-1:0] idex_rt_addr_o,
  output logic [RADDR_W-1:0] idex_rd_addr_o,
  output logic [DATA_W-1:0]  idex_instr_o,
  output logic               idex_regdest_o,
  output logic               idex_jump_o,
  output logic               idex_branch_o,
  output logic               idex_memread_o,
  output logic               idex_memtoreg_o,
  output logic               idex_memwrite_o,
  output logic               idex_alusrc_o,
  output logic               idex_regwrite_o,
  output logic [ALUOP_W-1:0] idex_aluop_o,
  // EX/MEM
  input  logic [DATA_W-1:0]  exmem_branch_addr_i,
  input  logic [DATA_W-1:0]  exmem_alu_res_i,
  input  logic [DATA_W-1:0]  exmem_rt_i,
  input  logic               exmem_zero_i,
  input  logic [RADDR_W-1:0] exmem_dest_addr_i,
  input  logic               exmem_jump_i,
  input  logic               exmem_branch_i,
  input  logic               exmem_memread_i,
  input  logic               exmem_memtoreg_i,
  input  logic               exmem_memwrite_i,
  input  logic               exmem_regwrite_i,
  output logic [DATA_W-1:0]  exmem_branch_addr_o,
  output logic [DATA_W-1:0]  exmem_alu_res_o,
  output logic [DATA_W-1:0]  exmem_rt_o,
  output logic               exmem_zero_o,
  output logic [RADDR_W-1:0] exmem_dest_addr_o,
  output logic               exmem_jump_o,
  output logic               exmem_branch_o,
  output logic               exmem_memread_o,
  output logic               exmem_memtoreg_o,
  output logic               exmem_memwrite_o,
  output logic               exmem_regwrite_o
);

  import pipeline_pkg::*;

  localparam int IFID_W    = 2 * DATA_W;
  localparam int IDEX_DW   = 5 * DATA_W + 3 * RADDR_W;
  localparam int EXMEM_DW  = 3 * DATA_W + 1 + RADDR_W;

  id_ex_ctrl_t  idex_ctrl_in_s;
  id_ex_ctrl_t  idex_ctrl_out_s;
  ex_mem_ctrl_t exmem_ctrl_in_s;
  ex_mem_ctrl_t exmem_ctrl_out_s;

  // ---------------- IF/ID: loads only while not stalled ----------------
  pipe_reg #(.W(IFID_W)) u_ifid (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (ifid_enable),
    .clr_i  (1'b0),
    .d_i    ({ifid_pc_plus1_i, ifid_instr_i}),
    .q_o    ({ifid_pc_plus1_o, ifid_instr_o})
  );

  // ---------------- ID/EX data: loads every cycle ----------------
  pipe_reg #(.W(IDEX_DW)) u_idex_data (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (1'b1),
    .clr_i  (1'b0),
    .d_i    ({idex_pc_plus1_i, idex_rs_i, idex_rt_i, idex_sext_i, idex_instr_i,
              idex_rs_addr_i, idex_rt_addr_i, idex_rd_addr_i}),
    .q_o    ({idex_pc_plus1_o, idex_rs_o, idex_rt_o, idex_sext_o, idex_instr_o,
              idex_rs_addr_o, idex_rt_addr_o, idex_rd_addr_o})
  );

  // ---------------- ID/EX control: zeroed on stall to form a bubble ----------------
  assign idex_ctrl_in_s.regdest  = idex_regdest_i;
  assign idex_ctrl_in_s.jump     = idex_jump_i;
  assign idex_ctrl_in_s.branch   = idex_branch_i;
  assign idex_ctrl_in_s.memread  = idex_memread_i;
  assign idex_ctrl_in_s.memtoreg = idex_memtoreg_i;
  assign idex_ctrl_in_s.memwrite = idex_memwrite_i;
  assign idex_ctrl_in_s.alusrc   = idex_alusrc_i;
  assign idex_ctrl_in_s.regwrite = idex_regwrite_i;
  assign idex_ctrl_in_s.aluop    = idex_aluop_i;

  pipe_reg #(.W(IDEX_CTRL_W)) u_idex_ctrl (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (1'b1),
    .clr_i  (idex_stall),
    .d_i    (idex_ctrl_in_s),
    .q_o    (idex_ctrl_out_s)
  );

  assign idex_regdest_o  = idex_ctrl_out_s.regdest;
  assign idex_jump_o     = idex_ctrl_out_s.jump;
  assign idex_branch_o   = idex_ctrl_out_s.branch;
  assign idex_memread_o  = idex_ctrl_out_s.memread;
  assign idex_memtoreg_o = idex_ctrl_out_s.memtoreg;
  assign idex_memwrite_o = idex_ctrl_out_s.memwrite;
  assign idex_alusrc_o   = idex_ctrl_out_s.alusrc;
  assign idex_regwrite_o = idex_ctrl_out_s.regwrite;
  assign idex_aluop_o    = idex_ctrl_out_s.aluop;

  // ---------------- EX/MEM: unconditional load ----------------
  pipe_reg #(.W(EXMEM_DW)) u_exmem_data (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (1'b1),
    .clr_i  (1'b0),
    .d_i    ({exmem_branch_addr_i, exmem_alu_res_i, exmem_rt_i, exmem_zero_i,
              exmem_dest_addr_i}),
    .q_o    ({exmem_branch_addr_o, exmem_alu_res_o, exmem_rt_o, exmem_zero_o,
              exmem_dest_addr_o})
  );

  assign exmem_ctrl_in_s.jump     = exmem_jump_i;
  assign exmem_ctrl_in_s.branch   = exmem_branch_i;
  assign exmem_ctrl_in_s.memread  = exmem_memread_i;
  assign exmem_ctrl_in_s.memtoreg = exmem_memtoreg_i;
  assign exmem_ctrl_in_s.memwrite = exmem_memwrite_i;
  assign exmem_ctrl_in_s.regwrite = exmem_regwrite_i;

  pipe_reg #(.W(EXMEM_CTRL_W)) u_exmem_ctrl (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (1'b1),
    .clr_i  (1'b0),
    .d_i    (exmem_ctrl_in_s),
    .q_o    (exmem_ctrl_out_s)
  );

  assign exmem_jump_o     = exmem_ctrl_out_s.jump;
  assign exmem_branch_o   = exmem_ctrl_out_s.branch;
  assign exmem_memread_o  = exmem_ctrl_out_s.memread;
  assign exmem_memtoreg_o = exmem_ctrl_out_s.memtoreg;
  assign exmem_memwrite_o = exmem_ctrl_out_s.memwrite;
  assign exmem_regwrite_o = exmem_ctrl_out_s.regwrite;

endmodule

// File: tb/tb_pipeline_stage_regs.sv
// Bench for pipeline_stage_regs: a stage-level model (each stage is a
// delayed copy of its input bundle) checked every falling edge, plus
// directed vectors with literal expectations.
module tb_pipeline_stage_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifid_enable;
  logic [31:0] ifid_pc_plus1_i, ifid_instr_i, ifid_pc_plus1_o, ifid_instr_o;
  logic        idex_stall;
  logic [31:0] idex_pc_plus1_i, idex_rs_i, idex_rt_i, idex_sext_i, idex_instr_i;
  logic [4:0]  idex_rs_addr_i, idex_rt_addr_i, idex_rd_addr_i;
  logic        idex_regdest_i, idex_jump_i, idex_branch_i, idex_memread_i;
  logic        idex_memtoreg_i, idex_memwrite_i, idex_alusrc_i, idex_regwrite_i;
  logic [1:0]  idex_aluop_i;
  logic [31:0] idex_pc_plus1_o, idex_rs_o, idex_rt_o, idex_sext_o, idex_instr_o;
  logic [4:0]  idex_rs_addr_o, idex_rt_addr_o, idex_rd_addr_o;
  logic        idex_regdest_o, idex_jump_o, idex_branch_o, idex_memread_o;
  logic        idex_memtoreg_o, idex_memwrite_o, idex_alusrc_o, idex_regwrite_o;
  logic [1:0]  idex_aluop_o;
  logic [31:0] exmem_branch_addr_i, exmem_alu_res_i, exmem_rt_i;
  logic        exmem_zero_i;
  logic [4:0]  exmem_dest_addr_i;
  logic        exmem_jump_i, exmem_branch_i, exmem_memread_i, exmem_memtoreg_i;
  logic        exmem_memwrite_i, exmem_regwrite_i;
  logic [31:0] exmem_branch_addr_o, exmem_alu_res_o, exmem_rt_o;
  logic        exmem_zero_o;
  logic [4:0]  exmem_dest_addr_o;
  logic        exmem_jump_o, exmem_branch_o, exmem_memread_o, exmem_memtoreg_o;
  logic        exmem_memwrite_o, exmem_regwrite_o;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  pipeline_stage_regs dut (
    .clk(clk), .reset(reset),
    .ifid_enable(ifid_enable), .ifid_pc_plus1_i(ifid_pc_plus1_i), .ifid_instr_i(ifid_instr_i),
    .ifid_pc_plus1_o(ifid_pc_plus1_o), .ifid_instr_o(ifid_instr_o),
    .idex_stall(idex_stall), .idex_pc_plus1_i(idex_pc_plus1_i), .idex_rs_i(idex_rs_i),
    .idex_rt_i(idex_rt_i), .idex_sext_i(idex_sext_i), .idex_rs_addr_i(idex_rs_addr_i),
    .idex_rt_addr_i(idex_rt_addr_i), .idex_rd_addr_i(idex_rd_addr_i), .idex_instr_i(idex_instr_i),
    .idex_regdest_i(idex_regdest_i), .idex_jump_i(idex_jump_i), .idex_branch_i(idex_branch_i),
    .idex_memread_i(idex_memread_i), .idex_memtoreg_i(idex_memtoreg_i),
    .idex_memwrite_i(idex_memwrite_i), .idex_alusrc_i(idex_alusrc_i),
    .idex_regwrite_i(idex_regwrite_i), .idex_aluop_i(idex_aluop_i),
    .idex_pc_plus1_o(idex_pc_plus1_o), .idex_rs_o(idex_rs_o), .idex_rt_o(idex_rt_o),
    .idex_sext_o(idex_sext_o), .idex_rs_addr_o(idex_rs_addr_o), .idex_rt_addr_o(idex_rt_addr_o),
    .idex_rd_addr_o(idex_rd_addr_o), .idex_instr_o(idex_instr_o),
    .idex_regdest_o(idex_regdest_o), .idex_jump_o(idex_jump_o), .idex_branch_o(idex_branch_o),
    .idex_memread_o(idex_memread_o), .idex_memtoreg_o(idex_memtoreg_o),
    .idex_memwrite_o(idex_memwrite_o), .idex_alusrc_o(idex_alusrc_o),
    .idex_regwrite_o(idex_regwrite_o), .idex_aluop_o(idex_aluop_o),
    .exmem_branch_addr_i(exmem_branch_addr_i), .exmem_alu_res_i(exmem_alu_res_i),
    .exmem_rt_i(exmem_rt_i), .exmem_zero_i(exmem_zero_i), .exmem_dest_addr_i(exmem_dest_addr_i),
    .exmem_jump_i(exmem_jump_i), .exmem_branch_i(exmem_branch_i), .exmem_memread_i(exmem_memread_i),
    .exmem_memtoreg_i(exmem_memtoreg_i), .exmem_memwrite_i(exmem_memwrite_i),
    .exmem_regwrite_i(exmem_regwrite_i),
    .exmem_branch_addr_o(exmem_branch_addr_o), .exmem_alu_res_o(exmem_alu_res_o),
    .exmem_rt_o(exmem_rt_o), .exmem_zero_o(exmem_zero_o), .exmem_dest_addr_o(exmem_dest_addr_o),
    .exmem_jump_o(exmem_jump_o), .exmem_branch_o(exmem_branch_o), .exmem_memread_o(exmem_memread_o),
    .exmem_memtoreg_o(exmem_memtoreg_o), .exmem_memwrite_o(exmem_memwrite_o),
    .exmem_regwrite_o(exmem_regwrite_o)
  );

  always #5 clk = ~clk;

  // Stage bundles, inputs and outputs in the same field order.
  logic [63:0]  in_ifid,   out_ifid;
  logic [174:0] in_idex_d, out_idex_d;
  logic [9:0]   in_idex_c, out_idex_c;
  logic [107:0] in_exmem,  out_exmem;

  assign in_ifid    = {ifid_pc_plus1_i, ifid_instr_i};
  assign out_ifid   = {ifid_pc_plus1_o, ifid_instr_o};
  assign in_idex_d  = {idex_pc_plus1_i, idex_rs_i, idex_rt_i, idex_sext_i, idex_instr_i,
                       idex_rs_addr_i, idex_rt_addr_i, idex_rd_addr_i};
  assign out_idex_d = {idex_pc_plus1_o, idex_rs_o, idex_rt_o, idex_sext_o, idex_instr_o,
                       idex_rs_addr_o, idex_rt_addr_o, idex_rd_addr_o};
  assign in_idex_c  = {idex_regdest_i, idex_jump_i, idex_branch_i, idex_memread_i,
                       idex_memtoreg_i, idex_memwrite_i, idex_alusrc_i, idex_regwrite_i, idex_aluop_i};
  assign out_idex_c = {idex_regdest_o, idex_jump_o, idex_branch_o, idex_memread_o,
                       idex_memtoreg_o, idex_memwrite_o, idex_alusrc_o, idex_regwrite_o, idex_aluop_o};
  assign in_exmem   = {exmem_branch_addr_i, exmem_alu_res_i, exmem_rt_i, exmem_zero_i,
                       exmem_dest_addr_i, exmem_jump_i, exmem_branch_i, exmem_memread_i,
                       exmem_memtoreg_i, exmem_memwrite_i, exmem_regwrite_i};
  assign out_exmem  = {exmem_branch_addr_o, exmem_alu_res_o, exmem_rt_o, exmem_zero_o,
                       exmem_dest_addr_o, exmem_jump_o, exmem_branch_o, exmem_memread_o,
                       exmem_memtoreg_o, exmem_memwrite_o, exmem_regwrite_o};

  // Model: each stage shows what was presented to it at the last edge.
  logic [63:0]  m_ifid   = '0;
  logic [174:0] m_idex_d = '0;
  logic [9:0]   m_idex_c = '0;
  logic [107:0] m_exmem  = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_ifid <= '0; m_idex_d <= '0; m_idex_c <= '0; m_exmem <= '0;
    end else begin
      if (ifid_enable) m_ifid <= in_ifid;
      m_idex_d <= in_idex_d;
      m_idex_c <= idex_stall ? 10'd0 : in_idex_c;
      m_exmem  <= in_exmem;
    end
  end

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_ifid",   256'(out_ifid),   256'(m_ifid));
      chk("model_idex_d", 256'(out_idex_d), 256'(m_idex_d));
      chk("model_idex_c", 256'(out_idex_c), 256'(m_idex_c));
      chk("model_exmem",  256'(out_exmem),  256'(m_exmem));
    end
  end

  task automatic all_zero(input string nm);
    chk({nm, "_ifid"},   256'(out_ifid),   256'd0);
    chk({nm, "_idex_d"}, 256'(out_idex_d), 256'd0);
    chk({nm, "_idex_c"}, 256'(out_idex_c), 256'd0);
    chk({nm, "_exmem"},  256'(out_exmem),  256'd0);
  endtask

  task automatic rand_inputs();
    ifid_enable = 1'($urandom); idex_stall = 1'($urandom);
    {ifid_pc_plus1_i, ifid_instr_i} = {$urandom, $urandom};
    {idex_pc_plus1_i, idex_rs_i, idex_rt_i, idex_sext_i, idex_instr_i} =
      {$urandom, $urandom, $urandom, $urandom, $urandom};
    {idex_rs_addr_i, idex_rt_addr_i, idex_rd_addr_i} = 15'($urandom);
    {idex_regdest_i, idex_jump_i, idex_branch_i, idex_memread_i, idex_memtoreg_i,
     idex_memwrite_i, idex_alusrc_i, idex_regwrite_i, idex_aluop_i} = 10'($urandom);
    {exmem_branch_addr_i, exmem_alu_res_i, exmem_rt_i} = {$urandom, $urandom, $urandom};
    {exmem_zero_i, exmem_dest_addr_i, exmem_jump_i, exmem_branch_i, exmem_memread_i,
     exmem_memtoreg_i, exmem_memwrite_i, exmem_regwrite_i} = 12'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] fetch [0:5];
  logic [31:0] log_alu [1:6];
  logic        log_rw  [1:6];
  int          k;
  logic        stall_now;
  logic        stalled_once;

  initial begin
    reset = 1'b1;
    rand_inputs();
    #1 reset = 1'b0;
    chk_en = 1'b1;

    // Reset held with random inputs and a running clock.
    for (int i = 0; i < 4; i++) begin
      rand_inputs();
      tick();
      all_zero("rst_hold");
    end
    reset = 1'b1;

    // IF/ID load then hold for 3 edges.
    ifid_enable = 1'b1; ifid_pc_plus1_i = 32'd5; ifid_instr_i = 32'h8C220004;
    tick();
    chk("ifid_load_instr", 256'(ifid_instr_o), 256'(32'h8C220004));
    ifid_enable = 1'b0; ifid_pc_plus1_i = 32'hFFFFFFFF; ifid_instr_i = 32'hFFFFFFFF;
    repeat (3) tick();
    chk("ifid_hold_instr", 256'(ifid_instr_o), 256'(32'h8C220004));
    chk("ifid_hold_pc",    256'(ifid_pc_plus1_o), 256'(32'd5));

    // ID/EX bubble.
    idex_regwrite_i = 1'b1; idex_memread_i = 1'b1; idex_aluop_i = 2'b10;
    idex_rt_addr_i = 5'd3; idex_stall = 1'b1;
    tick();
    chk("bubble_ctrl",    256'(out_idex_c),     256'd0);
    chk("bubble_rt_addr", 256'(idex_rt_addr_o), 256'(5'd3));

    // ID/EX normal load.
    idex_stall = 1'b0; idex_rs_i = 32'h11; idex_rt_i = 32'h22; idex_sext_i = 32'hFFFFFFFC;
    tick();
    chk("idex_rs",       256'(idex_rs_o),       256'(32'h11));
    chk("idex_rt",       256'(idex_rt_o),       256'(32'h22));
    chk("idex_sext",     256'(idex_sext_o),     256'(32'hFFFFFFFC));
    chk("idex_regwrite", 256'(idex_regwrite_o), 256'(1'b1));
    chk("idex_aluop",    256'(idex_aluop_o),    256'(2'b10));

    // EX/MEM load, then async reset between edges.
    exmem_alu_res_i = 32'h10; exmem_zero_i = 1'b1; exmem_branch_i = 1'b1;
    exmem_dest_addr_i = 5'd7;
    tick();
    chk("exmem_alu",    256'(exmem_alu_res_o),   256'(32'h10));
    chk("exmem_zero",   256'(exmem_zero_o),      256'(1'b1));
    chk("exmem_branch", 256'(exmem_branch_o),    256'(1'b1));
    chk("exmem_dest",   256'(exmem_dest_addr_o), 256'(5'd7));
    #2 reset = 1'b0;
    #1 all_zero("midcycle_rst");
    tick();
    reset = 1'b1;

    // Three-instruction stream with a single stall while instr 2 is in ID.
    fetch[0] = 32'h11; fetch[1] = 32'h22; fetch[2] = 32'h33;
    fetch[3] = 32'h0;  fetch[4] = 32'h0;  fetch[5] = 32'h0;
    rand_inputs();
    k = 0; stalled_once = 1'b0;
    ifid_enable = 1'b1; idex_stall = 1'b0; ifid_instr_i = fetch[0];
    idex_regwrite_i = 1'b1; exmem_alu_res_i = 32'h0; exmem_regwrite_i = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      log_alu[c] = exmem_alu_res_o;
      log_rw[c]  = exmem_regwrite_o;
      if (ifid_enable) k++;
      stall_now = (ifid_instr_o == 32'h22) && !stalled_once;
      if (stall_now) stalled_once = 1'b1;
      ifid_enable = !stall_now;
      idex_stall  = stall_now;
      ifid_instr_i = fetch[k];
      idex_instr_i = ifid_instr_o;
      idex_regwrite_i = 1'b1;
      exmem_alu_res_i = idex_instr_o;
      exmem_regwrite_i = idex_regwrite_o;
    end
    chk("stream_e3_alu", 256'(log_alu[3]), 256'(32'h11));
    chk("stream_e3_rw",  256'(log_rw[3]),  256'(1'b1));
    chk("stream_e4_alu", 256'(log_alu[4]), 256'(32'h22));
    chk("stream_e4_rw",  256'(log_rw[4]),  256'(1'b0));
    chk("stream_e5_alu", 256'(log_alu[5]), 256'(32'h22));
    chk("stream_e5_rw",  256'(log_rw[5]),  256'(1'b1));
    chk("stream_e6_alu", 256'(log_alu[6]), 256'(32'h33));
    chk("stream_e6_rw",  256'(log_rw[6]),  256'(1'b1));

    // A few random cycles checked only by the model.
    for (int i = 0; i < 20; i++) begin
      rand_inputs();
      tick();
    end
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
